reg_scoreboard: RTL and testbench

//  Hazard and write-port controller for the register file in the ID stage.

---
 rtl/reg_scoreboard.sv | 121 ++++++++++++
 tb/tb_reg_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard and write-port arbiter for the ID stage: tracks loads in flight, stalls on RAW/WAW hazards.
// Optional SB_BYPASS_EN adds id_fwd1/id_fwd2 so a dependent instruction can issue in the load-accept cycle.
module reg_scoreboard #(
  parameter int REG_NUM     = 32,
  parameter int LOG_REG_NUM = 5,
  parameter int DATA_SIZE   = 32,
  parameter int LQ_DEPTH    = 4,
  localparam int PTR_W      = $clog2(LQ_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [LOG_REG_NUM-1:0] id_rs1,
  input  logic [LOG_REG_NUM-1:0] id_rs2,
  input  logic [LOG_REG_NUM-1:0] id_rd,
  input  logic                   id_is_load,
  output logic                   id_stall,
`ifdef SB_BYPASS_EN
  output logic                   id_fwd1,
  output logic                   id_fwd2,
`endif
  input  logic                   alu_wb_valid,
  input  logic [LOG_REG_NUM-1:0] alu_wb_rd,
  input  logic [DATA_SIZE-1:0]   alu_wb_data,
  input  logic                   ld_rvalid,
  input  logic [DATA_SIZE-1:0]   ld_rdata,
  output logic                   ld_rready,
  output logic                   rf_regwrite,
  output logic [LOG_REG_NUM-1:0] rf_write_rd,
  output logic [DATA_SIZE-1:0]   rf_write_data,
  output logic [CNT_W-1:0]       lq_count
);

  logic [REG_NUM-1:0]                     busy, busy_nxt;
  logic [LQ_DEPTH-1:0][LOG_REG_NUM-1:0]   lq_rd;
  logic [PTR_W-1:0]                       wr_ptr, rd_ptr;
  logic [LOG_REG_NUM-1:0]                 head_rd;
  logic                                   lq_full, ld_accept, ld_issue;
  logic                                   rs1_busy, rs2_busy, head_nz;

  assign head_rd   = lq_rd[rd_ptr];
  assign head_nz   = (head_rd != '0);
  assign lq_full   = (lq_count == CNT_W'(LQ_DEPTH));

  // ALU owns the write port whenever it asks; loads wait
  assign ld_rready = !rst && (lq_count != '0) && !alu_wb_valid;
  assign ld_accept = ld_rvalid && ld_rready;

`ifdef SB_BYPASS_EN
  logic fwd1_hit, fwd2_hit;
  assign fwd1_hit = ld_accept && head_nz && (id_rs1 == head_rd);
  assign fwd2_hit = ld_accept && head_nz && (id_rs2 == head_rd);
  assign rs1_busy = busy[id_rs1] && !fwd1_hit;
  assign rs2_busy = busy[id_rs2] && !fwd2_hit;
  assign id_fwd1  = id_valid && fwd1_hit;
  assign id_fwd2  = id_valid && fwd2_hit;
`else
  assign rs1_busy = busy[id_rs1];
  assign rs2_busy = busy[id_rs2];
`endif

  // WAW on rd always uses registered busy, even with bypass
  assign id_stall = !rst && id_valid &&
                    (rs1_busy || rs2_busy || busy[id_rd] || (id_is_load && lq_full));
  assign ld_issue = id_valid && id_is_load && !id_stall;

  always_comb begin
    rf_regwrite   = 1'b0;
    rf_write_rd   = '0;
    rf_write_data = '0;
    if (!rst) begin
      if (alu_wb_valid) begin
        rf_regwrite   = (alu_wb_rd != '0);
        rf_write_rd   = alu_wb_rd;
        rf_write_data = alu_wb_data;
      end else if (ld_accept) begin
        rf_regwrite   = head_nz;
        rf_write_rd   = head_rd;
        rf_write_data = ld_rdata;
      end
    end
  end

  // clear first so a same-cycle set on the popped rd wins
  always_comb begin
    busy_nxt = busy;
    if (ld_accept)
      busy_nxt[head_rd] = 1'b0;
    if (ld_issue)
      busy_nxt[id_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      busy <= busy_nxt;
      if (ld_issue)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (ld_accept)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({ld_issue, ld_accept})
        2'b10:   lq_count <= lq_count + CNT_W'(1);
        2'b01:   lq_count <= lq_count - CNT_W'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  // queue storage needs no reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (ld_issue)
      lq_rd[wr_ptr] <= id_rd;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table for the corner cases, then random traffic vs a queue-based model.
// Define SB_BYPASS_EN when compiling to exercise the bypass variant.
module tb_reg_scoreboard;
  localparam int LQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_load, id_stall;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        ld_rvalid, ld_rready;
  logic [31:0] ld_rdata;
  logic        rf_regwrite;
  logic [4:0]  rf_write_rd;
  logic [31:0] rf_write_data;
  logic [2:0]  lq_count;
`ifdef SB_BYPASS_EN
  logic        id_fwd1, id_fwd2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_stall(id_stall),
`ifdef SB_BYPASS_EN
    .id_fwd1(id_fwd1), .id_fwd2(id_fwd2),
`endif
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_rready(ld_rready),
    .rf_regwrite(rf_regwrite), .rf_write_rd(rf_write_rd), .rf_write_data(rf_write_data),
    .lq_count(lq_count)
  );

  typedef struct {
    logic        r, iv;
    logic [4:0]  s1, s2, d;
    logic        ld, av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [31:0] ldt;
    logic        st, stb, f1, rr, we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [2:0]  c;
  } vec_t;

  function automatic vec_t mk(input logic r, iv, input logic [4:0] s1, s2, d,
                              input logic ld, av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [31:0] ldt,
                              input logic st, stb, f1, rr, we, input logic [4:0] wrd,
                              input logic [31:0] wd, input logic [2:0] c);
    vec_t v;
    v.r = r; v.iv = iv; v.s1 = s1; v.s2 = s2; v.d = d; v.ld = ld; v.av = av; v.ard = ard;
    v.ad = ad; v.lv = lv; v.ldt = ldt; v.st = st; v.stb = stb; v.f1 = f1; v.rr = rr;
    v.we = we; v.wrd = wrd; v.wd = wd; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, iv, input logic [4:0] s1, s2, d, input logic ld, av,
                       input logic [4:0] ard, input logic [31:0] ad, input logic lv,
                       input logic [31:0] ldt);
    rst = r; id_valid = iv; id_rs1 = s1; id_rs2 = s2; id_rd = d; id_is_load = ld;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad; ld_rvalid = lv; ld_rdata = ldt;
  endtask

  // reference model state
  bit          busy_m [32];
  int unsigned q_m [$];

  vec_t tbl [$];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //                r iv s1 s2 d  ld av ard ad     lv ldt            st stb f1 rr we wrd wd            c
    tbl.push_back(mk(1, 1, 5, 6, 7, 1, 1, 3, 32'h11, 1, 32'h99,        0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 1, 5, 6, 7, 0, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    // load-use on x5
    tbl.push_back(mk(0, 1, 1, 2, 5, 1, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 1, 5, 0, 6, 0, 0, 0, 0,      0, 0,             1, 1, 0, 1, 0, 0, 0,            1));
    tbl.push_back(mk(0, 1, 5, 0, 6, 0, 0, 0, 0,      1, 32'hDEADBEEF,  1, 0, 1, 1, 1, 5, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 1, 5, 0, 6, 0, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    // ALU beats load return
    tbl.push_back(mk(0, 1, 0, 0, 8, 1, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 32'hCAFEF00D,  0, 0, 0, 0, 1, 3, 32'h11,       1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'hCAFEF00D,  0, 0, 0, 1, 1, 8, 32'hCAFEF00D, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    // fill queue, full stall, in-order retire with pointer wrap
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 0,      0, 0,             0, 0, 0, 1, 0, 0, 0,            1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0,      0, 0,             0, 0, 0, 1, 0, 0, 0,            2));
    tbl.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, 0,      0, 0,             0, 0, 0, 1, 0, 0, 0,            3));
    tbl.push_back(mk(0, 1, 0, 0, 9, 1, 0, 0, 0,      0, 0,             1, 1, 0, 1, 0, 0, 0,            4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'h1001,      0, 0, 0, 1, 1, 1, 32'h1001,     4));
    tbl.push_back(mk(0, 1, 0, 0, 9, 1, 0, 0, 0,      1, 32'h1002,      0, 0, 0, 1, 1, 2, 32'h1002,     3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'h1003,      0, 0, 0, 1, 1, 3, 32'h1003,     3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'h1004,      0, 0, 0, 1, 1, 4, 32'h1004,     2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'h1009,      0, 0, 0, 1, 1, 9, 32'h1009,     1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    // x0 load and x0 ALU writeback
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,      0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      0, 0,             0, 0, 0, 1, 0, 0, 0,            1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'h55,        0, 0, 0, 1, 0, 0, 0,            1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h77, 0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    // reset with two loads outstanding
    tbl.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0,     0, 0,             0, 0, 0, 0, 0, 0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 11, 1, 0, 0, 0,     0, 0,             0, 0, 0, 1, 0, 0, 0,            1));
    tbl.push_back(mk(1, 1, 10, 0, 12, 0, 0, 0, 0,    0, 0,             0, 0, 0, 0, 0, 0, 0,            2));
    tbl.push_back(mk(0, 1, 10, 11, 12, 0, 0, 0, 0,   1, 32'h33,        0, 0, 0, 0, 0, 0, 0,            0));

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.r, v.iv, v.s1, v.s2, v.d, v.ld, v.av, v.ard, v.ad, v.lv, v.ldt);
      @(negedge clk);
`ifdef SB_BYPASS_EN
      chk($sformatf("vec%0d id_stall", i), 32'(id_stall), 32'(v.stb));
      chk($sformatf("vec%0d id_fwd1", i), 32'(id_fwd1), 32'(v.f1));
`else
      chk($sformatf("vec%0d id_stall", i), 32'(id_stall), 32'(v.st));
`endif
      chk($sformatf("vec%0d ld_rready", i), 32'(ld_rready), 32'(v.rr));
      chk($sformatf("vec%0d rf_regwrite", i), 32'(rf_regwrite), 32'(v.we));
      chk($sformatf("vec%0d lq_count", i), 32'(lq_count), 32'(v.c));
      if (v.we) begin
        chk($sformatf("vec%0d rf_write_rd", i), 32'(rf_write_rd), 32'(v.wrd));
        chk($sformatf("vec%0d rf_write_data", i), rf_write_data, v.wd);
      end
      @(posedge clk);
      #1;
    end

    // random traffic; start from a known-empty state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    foreach (busy_m[i]) busy_m[i] = 0;
    q_m.delete();

    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        r, iv, ld, av, lv;
      logic [4:0]  s1, s2, d, ard;
      logic [31:0] ad, ldt;
      int unsigned head;
      bit          e_rr, e_acc, e_st, e_we, b1, b2;
      int unsigned e_rd;
      logic [31:0] e_wd;

      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      ld  = $urandom_range(0, 1);
      av  = ($urandom_range(0, 9) < 3);
      lv  = $urandom_range(0, 1);
      s1  = 5'($urandom_range(0, 7));
      s2  = 5'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 7));
      ard = 5'($urandom_range(0, 7));
      ad  = $urandom;
      ldt = $urandom;
      drive(r, iv, s1, s2, d, ld, av, ard, ad, lv, ldt);

      head  = (q_m.size() != 0) ? q_m[0] : 0;
      e_rr  = !r && (q_m.size() != 0) && !av;
      e_acc = lv && e_rr;
      b1 = busy_m[s1];
      b2 = busy_m[s2];
`ifdef SB_BYPASS_EN
      if (e_acc && head != 0 && s1 == head) b1 = 0;
      if (e_acc && head != 0 && s2 == head) b2 = 0;
`endif
      e_st = !r && iv && (b1 || b2 || busy_m[d] || (ld && q_m.size() == LQ));
      e_we = 0; e_rd = 0; e_wd = 0;
      if (!r && av) begin
        e_we = (ard != 0); e_rd = ard; e_wd = ad;
      end else if (e_acc) begin
        e_we = (head != 0); e_rd = head; e_wd = ldt;
      end

      @(negedge clk);
      chk("rnd id_stall", 32'(id_stall), 32'(e_st));
      chk("rnd ld_rready", 32'(ld_rready), 32'(e_rr));
      chk("rnd rf_regwrite", 32'(rf_regwrite), 32'(e_we));
      chk("rnd lq_count", 32'(lq_count), q_m.size());
      if (e_we) begin
        chk("rnd rf_write_rd", 32'(rf_write_rd), e_rd);
        chk("rnd rf_write_data", rf_write_data, e_wd);
      end

      if (r) begin
        foreach (busy_m[i]) busy_m[i] = 0;
        q_m.delete();
      end else begin
        if (e_acc) begin
          void'(q_m.pop_front());
          if (head != 0) busy_m[head] = 0;
        end
        if (iv && ld && !e_st) begin
          q_m.push_back(d);
          if (d != 0) busy_m[d] = 1;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
